// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the two-port data-memory arbiter.
// Holds the arbiter state encoding and the burst counter width helper.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int NUM_PORTS = 2;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    // Counter must hold 0..MAX_BURST inclusive.
    function automatic int burst_cnt_width(input int max_burst);
        return clog2(max_burst + 1);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of both requester ports plus the data-memory side of the arbiter.
// master = requesters and memory model, slave = the arbiter itself.
interface dmem_port_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic                  p0_req_valid;
    logic                  p0_req_ready;
    logic                  p0_req_we;
    logic [ADDR_WIDTH-1:0] p0_req_addr;
    logic [DATA_WIDTH-1:0] p0_req_wdata;
    logic                  p0_rsp_valid;
    logic [DATA_WIDTH-1:0] p0_rsp_rdata;

    logic                  p1_req_valid;
    logic                  p1_req_ready;
    logic                  p1_req_we;
    logic [ADDR_WIDTH-1:0] p1_req_addr;
    logic [DATA_WIDTH-1:0] p1_req_wdata;
    logic                  p1_rsp_valid;
    logic [DATA_WIDTH-1:0] p1_rsp_rdata;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_write;
    logic                  mem_read;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        input  p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        input  p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        input  mem_addr, mem_wdata, mem_write, mem_read,
        output mem_rdata
    );

    modport slave (
        input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
        output p0_req_ready, p0_rsp_valid, p0_rsp_rdata,
        input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
        output p1_req_ready, p1_rsp_valid, p1_rsp_rdata,
        output mem_addr, mem_wdata, mem_write, mem_read,
        input  mem_rdata
    );

endinterface

// File: rtl/dmem_rsp_reg.sv
// Per-port read response register: captures memory read data for an accepted
// read and presents it with a one-cycle valid pulse; data holds afterwards.
module dmem_rsp_reg #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata
);

    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;

    always_comb begin
        rsp_valid_d = load;
        rsp_rdata_d = load ? load_data : rsp_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter for the single-port data memory with a burst cap per owner.
// Define DMEM_ARB_RR_EN for round-robin tie-break; otherwise port 0 wins ties.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input logic                clk,
    input logic                rst,
    dmem_port_arbiter_if.slave bus
);

    localparam int                 CNT_W   = burst_cnt_width(MAX_BURST);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);

    logic [NUM_PORTS-1:0]  req_valid;
    logic [NUM_PORTS-1:0]  req_we;
    logic [ADDR_WIDTH-1:0] req_addr  [NUM_PORTS];
    logic [DATA_WIDTH-1:0] req_wdata [NUM_PORTS];
    logic [NUM_PORTS-1:0]  grant;
    logic [NUM_PORTS-1:0]  rd_load;
    logic [NUM_PORTS-1:0]  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata [NUM_PORTS];

    logic accept;
    logic gsel;
    logic tie_pick;

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

    assign req_valid    = {bus.p1_req_valid, bus.p0_req_valid};
    assign req_we       = {bus.p1_req_we, bus.p0_req_we};
    assign req_addr[0]  = bus.p0_req_addr;
    assign req_addr[1]  = bus.p1_req_addr;
    assign req_wdata[0] = bus.p0_req_wdata;
    assign req_wdata[1] = bus.p1_req_wdata;

`ifdef DMEM_ARB_RR_EN
    logic rr_last_q, rr_last_d;
    assign tie_pick = ~rr_last_q;
`else
    assign tie_pick = 1'b0;
`endif

    // Grant only ever goes to a port whose valid is high, so grant == accept.
    always_comb begin
        grant = '0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    if (req_valid[0] && req_valid[1]) begin
                        grant[tie_pick] = 1'b1;
                    end else begin
                        grant = req_valid;
                    end
                end
                OWN0: begin
                    if (req_valid[0] && (burst_cnt_q < CNT_MAX || !req_valid[1])) begin
                        grant[0] = 1'b1;
                    end else if (req_valid[1]) begin
                        grant[1] = 1'b1;
                    end
                end
                OWN1: begin
                    if (req_valid[1] && (burst_cnt_q < CNT_MAX || !req_valid[0])) begin
                        grant[1] = 1'b1;
                    end else if (req_valid[0]) begin
                        grant[0] = 1'b1;
                    end
                end
                default: grant = '0;
            endcase
        end
    end

    assign accept = |grant;
    assign gsel   = grant[1];

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
`ifdef DMEM_ARB_RR_EN
        rr_last_d   = rr_last_q;
`endif
        if (accept) begin
            state_d = gsel ? OWN1 : OWN0;
            if (state_d == state_q) begin
                burst_cnt_d = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + CNT_ONE;
            end else begin
                burst_cnt_d = CNT_ONE;
            end
`ifdef DMEM_ARB_RR_EN
            rr_last_d = gsel;
`endif
        end else if (state_q != IDLE) begin
            state_d     = IDLE;
            burst_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q <= 1'b1;
        end else begin
            rr_last_q <= rr_last_d;
        end
    end
`endif

    assign bus.p0_req_ready = grant[0];
    assign bus.p1_req_ready = grant[1];

    assign bus.mem_addr  = accept ? req_addr[gsel]  : '0;
    assign bus.mem_wdata = accept ? req_wdata[gsel] : '0;
    assign bus.mem_write = accept &  req_we[gsel];
    assign bus.mem_read  = accept & ~req_we[gsel];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PORTS; gi++) begin : g_rsp
            assign rd_load[gi] = grant[gi] & ~req_we[gi];

            dmem_rsp_reg #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_rsp_reg (
                .clk       (clk),
                .rst       (rst),
                .load      (rd_load[gi]),
                .load_data (bus.mem_rdata),
                .rsp_valid (rsp_valid[gi]),
                .rsp_rdata (rsp_rdata[gi])
            );
        end
    endgenerate

    assign bus.p0_rsp_valid = rsp_valid[0];
    assign bus.p0_rsp_rdata = rsp_rdata[0];
    assign bus.p1_rsp_valid = rsp_valid[1];
    assign bus.p1_rsp_rdata = rsp_rdata[1];

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter: stimulus pushes expected grants and
// read responses, a negedge monitor pops and compares them.
module tb_dmem_port_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int MB = 4;

    typedef struct packed {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } acc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dmem_port_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_port_arbiter #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model: asynchronous read, write on posedge.
    logic [DW-1:0] mem [256];
    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (bus.mem_write) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 32'hA5A5_0000 + DW'(i);
    end

    acc_t          acc_q  [$];
    logic [DW-1:0] rsp_q0 [$];
    logic [DW-1:0] rsp_q1 [$];
    int checks = 0;
    int errors = 0;
    int wait0  = 0;
    int wait1  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (p == 0) begin
            bus.p0_req_valid = v; bus.p0_req_we = we; bus.p0_req_addr = a; bus.p0_req_wdata = d;
        end else begin
            bus.p1_req_valid = v; bus.p1_req_we = we; bus.p1_req_addr = a; bus.p1_req_wdata = d;
        end
    endtask

    task automatic expect_rd(input int p, input logic [AW-1:0] a, input logic [DW-1:0] data);
        acc_t e;
        e.port = p[0]; e.we = 1'b0; e.addr = a; e.wdata = '0;
        acc_q.push_back(e);
        if (p == 0) rsp_q0.push_back(data);
        else        rsp_q1.push_back(data);
    endtask

    task automatic expect_wr(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d);
        acc_t e;
        e.port = p[0]; e.we = 1'b1; e.addr = a; e.wdata = d;
        acc_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: grants, memory drive, responses and the fairness bound.
    always @(negedge clk) begin
        acc_t e;
        logic [DW-1:0] r;
        if (bus.p0_req_ready || bus.p1_req_ready) begin
            check("one_grant", {bus.p0_req_ready, bus.p1_req_ready}, 2'b01 << bus.p0_req_ready);
            check("ready_needs_valid",
                  (bus.p0_req_ready & ~bus.p0_req_valid) | (bus.p1_req_ready & ~bus.p1_req_valid), 0);
            if (acc_q.size() == 0) begin
                check("unexpected_grant", {bus.p1_req_ready, bus.mem_addr}, 0);
            end else begin
                e = acc_q.pop_front();
                $display("grant p%0d we=%0d addr=%02h wdata=%08h", bus.p1_req_ready,
                         bus.mem_write, bus.mem_addr, bus.mem_wdata);
                check("grant_port", bus.p1_req_ready, e.port);
                check("mem_addr", bus.mem_addr, e.addr);
                check("mem_wdata", bus.mem_wdata, e.wdata);
                check("mem_write", bus.mem_write, e.we);
                check("mem_read", bus.mem_read, !e.we);
            end
        end else begin
            check("idle_bus", {bus.mem_write, bus.mem_read}, 0);
        end
        if (bus.p0_rsp_valid) begin
            if (rsp_q0.size() == 0) begin
                check("p0_unexpected_rsp", bus.p0_rsp_rdata, 0);
                if (bus.p0_rsp_rdata == 0) check("p0_unexpected_rsp", 1, 0);
            end else begin
                r = rsp_q0.pop_front();
                $display("rsp p0 rdata=%08h", bus.p0_rsp_rdata);
                check("p0_rsp_rdata", bus.p0_rsp_rdata, r);
            end
        end
        if (bus.p1_rsp_valid) begin
            if (rsp_q1.size() == 0) begin
                check("p1_unexpected_rsp", bus.p1_rsp_rdata, 0);
                if (bus.p1_rsp_rdata == 0) check("p1_unexpected_rsp", 1, 0);
            end else begin
                r = rsp_q1.pop_front();
                $display("rsp p1 rdata=%08h", bus.p1_rsp_rdata);
                check("p1_rsp_rdata", bus.p1_rsp_rdata, r);
            end
        end
        if (!rst) begin
            wait0 = (bus.p0_req_valid && !bus.p0_req_ready) ? wait0 + 1 : 0;
            wait1 = (bus.p1_req_valid && !bus.p1_req_ready) ? wait1 + 1 : 0;
            if (wait0 > 0) check("p0_wait_bound", wait0 > MB, 0);
            if (wait1 > 0) check("p1_wait_bound", wait1 > MB, 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout: simulation did not finish");
        $fatal(1, "watchdog");
    end

    localparam logic [11:0] BURST_TBL = 12'b0000_1111_0000; // bit c = owner in cycle c

    initial begin
        int b0;
        int b1;
        logic g;
        logic [11:0] tbl;
        tbl = BURST_TBL;

        // Reset held three cycles with both ports requesting.
        drive(0, 1'b1, 1'b0, 8'h01, '0);
        drive(1, 1'b1, 1'b0, 8'h02, '0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_ready", {bus.p0_req_ready, bus.p1_req_ready}, 0);
            check("rst_mem_en", {bus.mem_write, bus.mem_read}, 0);
            check("rst_rsp_valid", {bus.p0_rsp_valid, bus.p1_rsp_valid}, 0);
            check("rst_rsp_rdata", {bus.p0_rsp_rdata, bus.p1_rsp_rdata}, 0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        expect_rd(0, 8'h01, 32'hA5A5_0001);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        tick;
        // Second tie from IDLE.
        drive(0, 1'b1, 1'b0, 8'h03, '0);
        drive(1, 1'b1, 1'b0, 8'h04, '0);
`ifdef DMEM_ARB_RR_EN
        expect_rd(1, 8'h04, 32'hA5A5_0004);
        tick;
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        expect_rd(0, 8'h03, 32'hA5A5_0003);
`else
        expect_rd(0, 8'h03, 32'hA5A5_0003);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        expect_rd(1, 8'h04, 32'hA5A5_0004);
`endif
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        tick;

        // Write then read-back, followed by back-to-back reads.
        drive(0, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        expect_wr(0, 8'h10, 32'hDEAD_BEEF);
        tick;
        drive(0, 1'b1, 1'b0, 8'h10, '0);
        expect_rd(0, 8'h10, 32'hDEAD_BEEF);
        tick;
        drive(0, 1'b1, 1'b0, 8'h05, '0);
        expect_rd(0, 8'h05, 32'hA5A5_0005);
        @(negedge clk);
        check("wr_rd_rsp_valid", bus.p0_rsp_valid, 1);
        check("wr_rd_rsp_rdata", bus.p0_rsp_rdata, 32'hDEAD_BEEF);
        tick;
        drive(0, 1'b1, 1'b0, 8'h06, '0);
        expect_rd(0, 8'h06, 32'hA5A5_0006);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        tick;

        // Burst cap: p0 owns, p1 joins and both stay valid.
        b0 = 0;
        b1 = 0;
        for (int c = 0; c < 12; c++) begin
            drive(0, 1'b1, 1'b0, 8'h20 + AW'(b0), '0);
            drive(1, c >= 1, 1'b0, 8'h40 + AW'(b1), '0);
            g = tbl[c];
            if (!g) begin
                expect_rd(0, 8'h20 + AW'(b0), 32'hA5A5_0020 + DW'(b0));
                b0++;
            end else begin
                expect_rd(1, 8'h40 + AW'(b1), 32'hA5A5_0040 + DW'(b1));
                b1++;
            end
            tick;
        end
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        tick;

        // Reset arriving while p1 is streaming reads.
        drive(1, 1'b1, 1'b0, 8'h50, '0);
        expect_rd(1, 8'h50, 32'hA5A5_0050);
        tick;
        drive(1, 1'b1, 1'b0, 8'h51, '0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_p1_ready", bus.p1_req_ready, 0);
        check("midrst_mem_read", bus.mem_read, 0);
        tick;
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 8'h07, '0);
        expect_rd(0, 8'h07, 32'hA5A5_0007);
        @(negedge clk);
        check("midrst_no_rsp", bus.p1_rsp_valid, 0);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        expect_rd(1, 8'h51, 32'hA5A5_0051);
        tick;
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        tick;

        // p1 withdraws its request while p0 owns under the cap.
        drive(0, 1'b1, 1'b0, 8'h60, '0);
        expect_rd(0, 8'h60, 32'hA5A5_0060);
        tick;
        drive(0, 1'b1, 1'b0, 8'h61, '0);
        drive(1, 1'b1, 1'b0, 8'h70, '0);
        expect_rd(0, 8'h61, 32'hA5A5_0061);
        tick;
        drive(0, 1'b1, 1'b0, 8'h62, '0);
        drive(1, 1'b0, 1'b0, 8'h00, '0);
        expect_rd(0, 8'h62, 32'hA5A5_0062);
        tick;
        drive(0, 1'b0, 1'b0, 8'h00, '0);
        repeat (3) tick;

        check("acc_queue_drained", acc_q.size(), 0);
        check("p0_rsp_queue_drained", rsp_q0.size(), 0);
        check("p1_rsp_queue_drained", rsp_q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
